// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian words, writes them from BASE_ADDRESS upward,
// verifies an XOR checksum and releases the CPU from reset only after a good image.
module program_loader #(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h00400000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  cpu_reset_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [15:0]           words_written_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_t;

  localparam logic [15:0] DEPTH_L = 16'(MEMORY_DEPTH);

  state_t      state_r;
  logic [15:0] len_r;
  logic [15:0] index_r;
  logic [1:0]  byte_cnt_r;
  logic [7:0]  xor_r;
  logic [23:0] shift_r;

  logic        accept_s;
  logic [15:0] len_s;
  logic [15:0] index_next_s;

  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign accept_s        = byte_valid_i && byte_ready_o;
  assign len_s           = {len_r[15:8], byte_i};
  assign index_next_s    = index_r + 16'd1;
  assign words_written_o = index_r;

  // Loader state machine with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      len_r         <= 16'd0;
      index_r       <= 16'd0;
      byte_cnt_r    <= 2'd0;
      xor_r         <= 8'd0;
      shift_r       <= 24'd0;
      byte_ready_o  <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_address_o <= BASE_ADDRESS;
      mem_data_o    <= '0;
      cpu_reset_o   <= 1'b1;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      case (state_r)
        IDLE, DONE, ERROR: begin
          if (start_i) begin
            state_r      <= LEN_HI;
            byte_ready_o <= 1'b1;
            index_r      <= 16'd0;
            byte_cnt_r   <= 2'd0;
            xor_r        <= 8'd0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            cpu_reset_o  <= 1'b1;
          end
        end
        LEN_HI: begin
          if (accept_s) begin
            len_r[15:8] <= byte_i;
            state_r     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept_s) begin
            len_r <= len_s;
            if (len_s == 16'd0) begin
              state_r <= CHECK;
            end else if (len_s > DEPTH_L) begin
              state_r      <= ERROR;
              error_o      <= 1'b1;
              byte_ready_o <= 1'b0;
            end else begin
              state_r <= DATA;
            end
          end
        end
        DATA: begin
          if (accept_s) begin
            shift_r    <= {shift_r[15:0], byte_i};
            xor_r      <= xor_fold(xor_r, byte_i);
            byte_cnt_r <= byte_cnt_r + 2'd1;
            // Fourth byte completes the word; the write strobe follows on the next cycle.
            if (byte_cnt_r == 2'd3) begin
              state_r       <= WRITE;
              byte_ready_o  <= 1'b0;
              mem_we_o      <= 1'b1;
              mem_data_o    <= DATA_WIDTH'({shift_r, byte_i});
              mem_address_o <= BASE_ADDRESS + DATA_WIDTH'({index_r, 2'b00});
            end
          end
        end
        WRITE: begin
          index_r      <= index_next_s;
          byte_ready_o <= 1'b1;
          state_r      <= (index_next_s == len_r) ? CHECK : DATA;
        end
        CHECK: begin
          if (accept_s) begin
            byte_ready_o <= 1'b0;
            if (byte_i == xor_r) begin
              state_r     <= DONE;
              done_o      <= 1'b1;
              cpu_reset_o <= 1'b0;
            end else begin
              state_r <= ERROR;
              error_o <= 1'b1;
            end
          end
        end
        default: begin
          state_r      <= IDLE;
          byte_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of whole-image loads, hand-written
// multi-cycle sequences, and randomized loads against an image-level reference model.
module tb_program_loader;

  localparam int          DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h00400000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_data_o;
  logic        cpu_reset_o;
  logic        done_o;
  logic        error_o;
  logic [15:0] words_written_o;

  program_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32), .BASE_ADDRESS(BASE)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .byte_valid_i(byte_valid_i),
    .byte_i(byte_i), .byte_ready_o(byte_ready_o), .mem_we_o(mem_we_o),
    .mem_address_o(mem_address_o), .mem_data_o(mem_data_o), .cpu_reset_o(cpu_reset_o),
    .done_o(done_o), .error_o(error_o), .words_written_o(words_written_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] img[0:63];
  logic        prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Captures every write strobe and checks it is a single cycle with the stream stalled.
  always @(negedge clk) begin
    if (!reset && mem_we_o) begin
      chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
      chk("ready_low_in_write", {31'd0, byte_ready_o}, 32'd0);
      wq.push_back('{addr: mem_address_o, data: mem_data_o});
    end
    prev_we = mem_we_o;
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int t;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    byte_valid_i = 1'b0;
    repeat (gap) begin
      byte_i = 8'($urandom);
      step();
    end
    byte_valid_i = 1'b1;
    byte_i       = b;
    t = 0;
    while (!byte_ready_o && t < 50) begin
      step();
      t++;
    end
    chk("ready_before_accept", {31'd0, byte_ready_o}, 32'd1);
    step();
    byte_valid_i = 1'b0;
  endtask

  task automatic do_load(input int n_len, input int n_data, input logic [7:0] cks,
                         input int gap, input bit mid_start);
    logic [15:0] len16;
    wq.delete();
    len16   = 16'(n_len);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    send_byte(len16[15:8], gap);
    send_byte(len16[7:0], gap);
    for (int i = 0; i < n_data; i++) begin
      for (int b = 0; b < 4; b++) send_byte(img[i][31-8*b -: 8], gap);
      if (mid_start && i == 10) begin
        start_i = 1'b1;
        step();
        start_i = 1'b0;
      end
    end
    if (n_len <= DEPTH) send_byte(cks, gap);
  endtask

  task automatic check_result(input string name, input bit exp_done, input bit exp_err,
                              input int exp_ww);
    chk({name, "_done"}, {31'd0, done_o}, {31'd0, exp_done});
    chk({name, "_error"}, {31'd0, error_o}, {31'd0, exp_err});
    chk({name, "_cpu_reset"}, {31'd0, cpu_reset_o}, {31'd0, !exp_done});
    chk({name, "_words"}, {16'd0, words_written_o}, 32'(exp_ww));
    chk({name, "_nwrites"}, 32'(wq.size()), 32'(exp_ww));
    for (int i = 0; i < wq.size() && i < exp_ww; i++) begin
      chk({name, "_addr"}, wq[i].addr, BASE + 32'(4 * i));
      chk({name, "_data"}, wq[i].data, img[i]);
    end
    step();
    chk({name, "_ready_after"}, {31'd0, byte_ready_o}, 32'd0);
  endtask

  function automatic logic [7:0] image_xor(input int n);
    logic [7:0] x = 8'd0;
    for (int i = 0; i < n; i++) x = x ^ img[i][31:24] ^ img[i][23:16] ^ img[i][15:8] ^ img[i][7:0];
    return x;
  endfunction

  typedef struct {
    int          n_len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  cks;
    bit          exp_done;
    bit          exp_err;
    int          exp_ww;
  } vec_t;

  vec_t vt[7];

  initial begin
    int          n;
    bit          bad;
    logic [7:0]  cks;

    // 0x4D is the XOR of the eight data bytes 20 08 00 05 00 08 48 20.
    vt[0] = '{2,  32'h20080005, 32'h00084820, 8'h4D, 1'b1, 1'b0, 2};
    vt[1] = '{2,  32'h20080005, 32'h00084820, 8'h00, 1'b0, 1'b1, 2};
    vt[2] = '{2,  32'h20080005, 32'h00084820, 8'h65, 1'b0, 1'b1, 2};
    vt[3] = '{0,  32'h0,        32'h0,        8'h00, 1'b1, 1'b0, 0};
    vt[4] = '{0,  32'h0,        32'h0,        8'h5A, 1'b0, 1'b1, 0};
    vt[5] = '{33, 32'h0,        32'h0,        8'h00, 1'b0, 1'b1, 0};
    vt[6] = '{1,  32'hDEADBEEF, 32'h0,        8'h22, 1'b1, 1'b0, 1};

    reset        = 1'b1;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_i       = 8'd0;
    repeat (2) step();
    chk("rst_ready", {31'd0, byte_ready_o}, 32'd0);
    chk("rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_addr", mem_address_o, BASE);
    chk("rst_data", mem_data_o, 32'd0);
    chk("rst_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
    chk("rst_flags", {30'd0, done_o, error_o}, 32'd0);
    chk("rst_words", {16'd0, words_written_o}, 32'd0);
    reset = 1'b0;
    step();
    chk("idle_ignores_bytes", {31'd0, byte_ready_o}, 32'd0);

    for (int v = 0; v < 7; v++) begin
      img[0] = vt[v].w0;
      img[1] = vt[v].w1;
      do_load(vt[v].n_len, (vt[v].n_len <= DEPTH) ? vt[v].n_len : 0, vt[v].cks, v % 2, 1'b0);
      check_result($sformatf("vec%0d", v), vt[v].exp_done, vt[v].exp_err, vt[v].exp_ww);
    end

    // Write latency: strobe is visible right after the edge taking the 4th byte, for one cycle.
    img[0] = 32'hA1B2C3D4;
    wq.delete();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("start_enters_len_hi", {31'd0, byte_ready_o}, 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    for (int b = 0; b < 4; b++) send_byte(img[0][31-8*b -: 8], 0);
    chk("lat_we", {31'd0, mem_we_o}, 32'd1);
    chk("lat_addr", mem_address_o, BASE);
    chk("lat_data", mem_data_o, 32'hA1B2C3D4);
    chk("lat_words_during_write", {16'd0, words_written_o}, 32'd0);
    step();
    chk("lat_we_drop", {31'd0, mem_we_o}, 32'd0);
    chk("lat_words_after", {16'd0, words_written_o}, 32'd1);
    chk("lat_data_hold", mem_data_o, 32'hA1B2C3D4);
    send_byte(image_xor(1), 0);
    check_result("lat", 1'b1, 1'b0, 1);

    // Reset mid-load after three data bytes aborts immediately.
    img[0] = 32'h11223344;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int b = 0; b < 3; b++) send_byte(img[0][31-8*b -: 8], 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, byte_ready_o}, 32'd0);
    chk("mid_rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("mid_rst_addr", mem_address_o, BASE);
    chk("mid_rst_data", mem_data_o, 32'd0);
    chk("mid_rst_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
    chk("mid_rst_flags", {30'd0, done_o, error_o}, 32'd0);
    chk("mid_rst_words", {16'd0, words_written_o}, 32'd0);
    step();
    reset = 1'b0;
    step();
    img[0] = 32'h20080005;
    img[1] = 32'h00084820;
    do_load(2, 2, image_xor(2), 0, 1'b0);
    check_result("after_rst", 1'b1, 1'b0, 2);

    // Randomized loads against the image-level model, ending with a full 32-word load.
    for (int r = 0; r < 6; r++) begin
      n = (r == 5) ? DEPTH : int'($urandom_range(DEPTH, 1));
      for (int i = 0; i < n; i++) img[i] = $urandom;
      bad = (r != 5) && ($urandom_range(2, 0) == 0);
      cks = image_xor(n) ^ (bad ? 8'($urandom_range(255, 1)) : 8'd0);
      do_load(n, n, cks, 3, r == 5);
      check_result($sformatf("rand%0d", r), !bad, bad, n);
    end

    // A new start in DONE clears the flags and reopens the stream.
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("restart_done", {31'd0, done_o}, 32'd0);
    chk("restart_error", {31'd0, error_o}, 32'd0);
    chk("restart_words", {16'd0, words_written_o}, 32'd0);
    chk("restart_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
    chk("restart_ready", {31'd0, byte_ready_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
